// File: rtl/icache_pkg.sv
// Shared types, constants and address-slicing helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned DEF_INDEX_BITS    = 7;
  localparam int unsigned DEF_MEM_ADDR_BITS = 18;

  localparam logic [1:0] IO_REGION = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_e;

  // Line index: word-address bits just above the byte offset.
  function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                             input int unsigned index_bits);
    return (addr >> 2) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  // Tag: significant address bits above the index; higher bits are ignored.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                           input int unsigned index_bits,
                                           input int unsigned mem_addr_bits);
    return (addr >> (index_bits + 2)) &
           ((32'd1 << (mem_addr_bits - 2 - index_bits)) - 32'd1);
  endfunction

  function automatic logic is_io(input logic [1:0] region);
    return region == IO_REGION;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid-bit vector (resettable, flash-clearable) plus tag/data storage
// with combinational read and synchronous write.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
  parameter int unsigned TAG_BITS   = DEF_MEM_ADDR_BITS - 2 - DEF_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] windex_i,
  input  logic [TAG_BITS-1:0]   wtag_i,
  input  logic [31:0]           wdata_i,
  input  logic [INDEX_BITS-1:0] rindex_i,
  output logic                  rvalid_o,
  output logic [TAG_BITS-1:0]   rtag_o,
  output logic [31:0]           rdata_o
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    valid_d;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  // Clear wins over a same-cycle install so a flush never leaves a stale line.
  always_comb begin
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = '0;
    end else if (we_i) begin
      valid_d[windex_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag/data need no reset: they are only trusted behind a valid bit.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[windex_i]  <= wtag_i;
      data_q[windex_i] <= wdata_i;
    end
  end

  assign rvalid_o = valid_q[rindex_i];
  assign rtag_o   = tag_q[rindex_i];
  assign rdata_o  = data_q[rindex_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and mem_control.
// Hits deliver the next cycle; misses issue one read and refill on return.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS    = DEF_INDEX_BITS,
  parameter int unsigned MEM_ADDR_BITS = DEF_MEM_ADDR_BITS,
  parameter int unsigned TAG_BITS      = MEM_ADDR_BITS - 2 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_addr_o,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_valid,
  input  logic [31:0] mc_inst,
  input  logic [31:0] mc_addr_back
);

  state_e      state_q, state_d;
  logic [31:0] miss_addr_q, miss_addr_d;
  logic        flushed_q, flushed_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] if_addr_q, if_addr_d;
  logic        mc_req_q, mc_req_d;
  logic [31:0] mc_addr_q, mc_addr_d;

  logic [INDEX_BITS-1:0] rindex;
  logic [INDEX_BITS-1:0] windex;
  logic [TAG_BITS-1:0]   ltag;
  logic [TAG_BITS-1:0]   wtag;
  logic [TAG_BITS-1:0]   rtag;
  logic                  rvalid;
  logic [31:0]           rdata;
  logic                  hit;
  logic                  refill;
  logic                  deliver;
  logic                  array_we;
  logic                  array_clear;

  assign rindex = INDEX_BITS'(addr_index(if_addr, INDEX_BITS));
  assign ltag   = TAG_BITS'(addr_tag(if_addr, INDEX_BITS, MEM_ADDR_BITS));
  assign windex = INDEX_BITS'(addr_index(miss_addr_q, INDEX_BITS));
  assign wtag   = TAG_BITS'(addr_tag(miss_addr_q, INDEX_BITS, MEM_ADDR_BITS));

  assign hit     = rvalid && (rtag == ltag) && !is_io(if_addr[17:16]);
  // Only a return that matches the outstanding miss completes it.
  assign refill  = (state_q == MISS) && mc_valid && (mc_addr_back == miss_addr_q);
  assign deliver = refill && if_req && (if_addr == miss_addr_q);

  // A flush anywhere in the miss window, including the return cycle, blocks install.
  assign array_we    = rdy && refill && !is_io(miss_addr_q[17:16]) && !flushed_q && !flush;
  assign array_clear = rdy && flush;

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (array_clear),
    .we_i     (array_we),
    .windex_i (windex),
    .wtag_i   (wtag),
    .wdata_i  (mc_inst),
    .rindex_i (rindex),
    .rvalid_o (rvalid),
    .rtag_o   (rtag),
    .rdata_o  (rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (if_req && !hit) begin
          state_d = MISS;
        end
      end
      MISS: begin
        if (refill) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    if_valid_d  = 1'b0;
    if_inst_d   = if_inst_q;
    if_addr_d   = if_addr_q;
    mc_req_d    = mc_req_q;
    mc_addr_d   = mc_addr_q;
    miss_addr_d = miss_addr_q;
    flushed_d   = flushed_q;
    case (state_q)
      IDLE: begin
        mc_req_d = 1'b0;
        if (if_req && hit) begin
          if_valid_d = 1'b1;
          if_inst_d  = rdata;
          if_addr_d  = if_addr;
        end else if (if_req) begin
          miss_addr_d = if_addr;
          mc_req_d    = 1'b1;
          mc_addr_d   = if_addr;
          flushed_d   = 1'b0;
        end
      end
      MISS: begin
        mc_req_d  = 1'b1;
        mc_addr_d = miss_addr_q;
        flushed_d = flushed_q | flush;
        if (refill) begin
          mc_req_d  = 1'b0;
          flushed_d = 1'b0;
          if (deliver) begin
            if_valid_d = 1'b1;
            if_inst_d  = mc_inst;
            if_addr_d  = miss_addr_q;
          end
        end
      end
      default: begin
        mc_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_addr_q <= '0;
      flushed_q   <= 1'b0;
      if_valid_q  <= 1'b0;
      if_inst_q   <= '0;
      if_addr_q   <= '0;
      mc_req_q    <= 1'b0;
      mc_addr_q   <= '0;
    end else if (rdy) begin
      miss_addr_q <= miss_addr_d;
      flushed_q   <= flushed_d;
      if_valid_q  <= if_valid_d;
      if_inst_q   <= if_inst_d;
      if_addr_q   <= if_addr_d;
      mc_req_q    <= mc_req_d;
      mc_addr_q   <= mc_addr_d;
    end
  end

  assign if_valid  = if_valid_q;
  assign if_inst   = if_inst_q;
  assign if_addr_o = if_addr_q;
  assign mc_req    = mc_req_q;
  assign mc_addr   = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: directed fetch sequences push expected deliveries
// and miss addresses; a monitor pops and compares as the DUT presents them.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_addr_o;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_valid;
  logic [31:0] mc_inst;
  logic [31:0] mc_addr_back;

  always #5 clk = ~clk;

  icache dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .flush        (flush),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_valid     (if_valid),
    .if_inst      (if_inst),
    .if_addr_o    (if_addr_o),
    .mc_req       (mc_req),
    .mc_addr      (mc_addr),
    .mc_valid     (mc_valid),
    .mc_inst      (mc_inst),
    .mc_addr_back (mc_addr_back)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_fetch[$];
  logic [31:0] exp_mc[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        new_out  = 1'b0;
  logic        mc_req_prev = 1'b0;

  // Backing memory contents seen by the mem_control model.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h00A0_0093;
      32'h0000_0300: return 32'h00B0_0113;
      32'h0000_0200: return 32'h00C0_0193;
      32'h0000_0400: return 32'h00D0_0213;
      32'h0000_0500: return 32'h00E0_0293;
      32'h0003_0000: return 32'hDEAD_BEEF;
      default:       return {a[15:0], 16'h0013};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] inst);
    exp_t e;
    e.addr = a;
    e.inst = inst;
    exp_fetch.push_back(e);
  endtask

  // Present one fetch, wait for its delivery and check latency (1 on hit, 5 on miss).
  task automatic fetch(input logic [31:0] a, input logic [31:0] inst, input bit miss,
                       input string name);
    int lat;
    bit got;
    if (miss) exp_mc.push_back(a);
    push_fetch(a, inst);
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = a;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (if_valid) got = 1'b1;
    end
    check({name, "_latency"}, 32'(lat), miss ? 32'd5 : 32'd1);
    @(negedge clk);
    if_req = 1'b0;
  endtask

  task automatic wait_mc(input string name);
    int n;
    n = 0;
    while (!mc_req && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_mc_req_wait"}, 32'(mc_req), 32'd1);
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int n;
    n = 0;
    while (!if_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  // mem_control model: answers each request three cycles after mc_req rises.
  initial begin
    int   cnt;
    logic busy;
    mc_valid     = 1'b0;
    mc_inst      = '0;
    mc_addr_back = '0;
    busy = 1'b0;
    cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mc_valid = 1'b0;
        busy     = 1'b0;
      end else if (mc_valid) begin
        if (rdy) begin
          mc_valid = 1'b0;
          busy     = 1'b0;
        end
      end else if (busy) begin
        if (!mc_req) begin
          busy = 1'b0;
        end else if (cnt <= 1) begin
          mc_valid     = 1'b1;
          mc_inst      = mem_word(mc_addr);
          mc_addr_back = mc_addr;
        end else begin
          cnt--;
        end
      end else if (mc_req) begin
        busy = 1'b1;
        cnt  = 3;
      end
    end
  end

  // Outputs in a cycle are fresh only if the preceding edge was not stalled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      new_out = rdy;
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t        e;
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      if (if_valid && new_out) begin
        if (exp_fetch.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_if_valid: got addr %h inst %h, none expected", if_addr_o, if_inst);
        end else begin
          e = exp_fetch.pop_front();
          check("if_addr_o", if_addr_o, e.addr);
          check("if_inst", if_inst, e.inst);
        end
      end
      if (mc_req && !mc_req_prev) begin
        if (exp_mc.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_mc_req: got mc_addr %h, none expected", mc_addr);
        end else begin
          ea = exp_mc.pop_front();
          check("mc_addr", mc_addr, ea);
        end
      end
      mc_req_prev = mc_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    rdy     = 1'b1;
    flush   = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_if_addr_o", if_addr_o, 32'd0);
    check("rst_mc_req", 32'(mc_req), 32'd0);
    check("rst_mc_addr", mc_addr, 32'd0);
    rst = 1'b0;

    // Cold miss then hit
    fetch(32'h100, 32'h00A0_0093, 1'b1, "cold_miss");
    fetch(32'h100, 32'h00A0_0093, 1'b0, "cold_hit");

    // Conflict on index 0x40
    fetch(32'h300, 32'h00B0_0113, 1'b1, "conflict_miss");
    fetch(32'h100, 32'h00A0_0093, 1'b1, "conflict_rerequest");
    fetch(32'h104, 32'h0104_0013, 1'b1, "fill_104");

    // Back-to-back hits, one per cycle
    push_fetch(32'h100, 32'h00A0_0093);
    push_fetch(32'h104, 32'h0104_0013);
    push_fetch(32'h100, 32'h00A0_0093);
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h100;
    @(negedge clk);
    check("burst_v0", 32'(if_valid), 32'd1);
    if_addr = 32'h104;
    @(negedge clk);
    check("burst_v1", 32'(if_valid), 32'd1);
    if_addr = 32'h100;
    @(negedge clk);
    check("burst_v2", 32'(if_valid), 32'd1);
    if_req = 1'b0;
    @(negedge clk);
    check("burst_end", 32'(if_valid), 32'd0);

    // rdy low for five cycles while a hit is on the outputs
    push_fetch(32'h100, 32'h00A0_0093);
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h100;
    @(negedge clk);
    check("stall_first_valid", 32'(if_valid), 32'd1);
    push_fetch(32'h104, 32'h0104_0013);
    if_addr = 32'h104;
    rdy     = 1'b0;
    repeat (4) @(negedge clk);
    repeat (1) begin
      @(negedge clk);
      check("stall_if_valid", 32'(if_valid), 32'd1);
      check("stall_if_inst", if_inst, 32'h00A0_0093);
      check("stall_if_addr_o", if_addr_o, 32'h100);
      check("stall_mc_req", 32'(mc_req), 32'd0);
    end
    rdy = 1'b1;
    @(negedge clk);
    check("resume_if_valid", 32'(if_valid), 32'd1);
    check("resume_if_addr_o", if_addr_o, 32'h104);
    if_req = 1'b0;
    @(negedge clk);
    check("resume_end", 32'(if_valid), 32'd0);
    fetch(32'h100, 32'h00A0_0093, 1'b0, "resume_hit");

    // Redirect mid-miss: 0x200 refill is dropped, 0x400 is looked up after it
    exp_mc.push_back(32'h200);
    exp_mc.push_back(32'h400);
    push_fetch(32'h400, 32'h00D0_0213);
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h200;
    wait_mc("redirect");
    @(negedge clk);
    if_addr = 32'h400;
    wait_valid("redirect", 9);
    @(negedge clk);
    if_req = 1'b0;
    fetch(32'h400, 32'h00D0_0213, 1'b0, "redirect_hit");

    // Flush during a miss: delivered but not installed
    exp_mc.push_back(32'h500);
    push_fetch(32'h500, 32'h00E0_0293);
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h500;
    wait_mc("flush_miss");
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_valid("flush_deliver", 3);
    @(negedge clk);
    if_req = 1'b0;
    fetch(32'h500, 32'h00E0_0293, 1'b1, "flush_rerequest");
    fetch(32'h100, 32'h00A0_0093, 1'b1, "flush_old_100");
    fetch(32'h104, 32'h0104_0013, 1'b1, "flush_old_104");

    // Flush coinciding with a hit: hit still delivered, line gone afterwards
    push_fetch(32'h104, 32'h0104_0013);
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h104;
    flush   = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("hit_flush_valid", 32'(if_valid), 32'd1);
    if_req = 1'b0;
    fetch(32'h104, 32'h0104_0013, 1'b1, "hit_flush_after");

    // I/O region is never installed
    fetch(32'h0003_0000, 32'hDEAD_BEEF, 1'b1, "io_first");
    fetch(32'h0003_0000, 32'hDEAD_BEEF, 1'b1, "io_second");

    // Reset in the middle of a miss
    exp_mc.push_back(32'h208);
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h208;
    wait_mc("rst_miss");
    @(negedge clk);
    rst    = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_miss_mc_req", 32'(mc_req), 32'd0);
    check("rst_miss_mc_addr", mc_addr, 32'd0);
    check("rst_miss_if_valid", 32'(if_valid), 32'd0);
    repeat (6) @(negedge clk);
    check("rst_miss_no_refill", 32'(if_valid), 32'd0);
    fetch(32'h104, 32'h0104_0013, 1'b1, "rst_invalid_104");
    fetch(32'h100, 32'h00A0_0093, 1'b1, "rst_invalid_100");
    fetch(32'h104, 32'h0104_0013, 1'b0, "rst_refill_hit");

    repeat (8) @(negedge clk);
    check("pending_fetches", 32'(exp_fetch.size()), 32'd0);
    check("pending_mc_reqs", 32'(exp_mc.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
